// File: rtl/simon_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : simon_seq_ctrl_if
// Purpose  : Sequence-memory port bundle between the Simon controller and RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface simon_seq_ctrl_if #(
    parameter int WIDTH = 6,
    parameter int PTR_W = 5
) ();
    logic [PTR_W-1:0] mem_w_ptr;
    logic             mem_w_en;
    logic [WIDTH-1:0] mem_data_in;
    logic [PTR_W-1:0] mem_r_ptr;
    logic             mem_r_en;
    logic [WIDTH-1:0] mem_data_out;

    modport master (
        output mem_w_ptr,
        output mem_w_en,
        output mem_data_in,
        output mem_r_ptr,
        output mem_r_en,
        input  mem_data_out
    );

    modport slave (
        input  mem_w_ptr,
        input  mem_w_en,
        input  mem_data_in,
        input  mem_r_ptr,
        input  mem_r_en,
        output mem_data_out
    );
endinterface
`default_nettype wire

// File: rtl/simon_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : simon_seq_ctrl
// Purpose  : Simon game sequencer: grows a random sequence in external memory,
//            plays it back on tick strobes and checks the player's replies.
// Revision : 1.0 - initial release
// ============================================================================
module simon_seq_ctrl #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 6,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] rand_val,
    input  logic             tick,
    input  logic             btn_valid,
    input  logic [WIDTH-1:0] btn_val,
    simon_seq_ctrl_if.master mem,
    output logic             show_valid,
    output logic [WIDTH-1:0] show_val,
    output logic [PTR_W:0]   level,
    output logic             busy,
    output logic             win,
    output logic             lose
);

    localparam logic [PTR_W:0]   c_DEPTH   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_ONE_LEN = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] c_ONE_IDX = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_APPEND    = 3'd1,
        S_PLAY_REQ  = 3'd2,
        S_PLAY_CAP  = 3'd3,
        S_PLAY_SHOW = 3'd4,
        S_IN_WAIT   = 3'd5,
        S_IN_REQ    = 3'd6,
        S_IN_CMP    = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W:0]   r_len;
    logic [PTR_W:0]   w_len_nxt;
    logic [PTR_W-1:0] r_idx;
    logic [PTR_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0] r_show_val;
    logic [WIDTH-1:0] w_show_val_nxt;
    logic [WIDTH-1:0] r_btn_val;
    logic [WIDTH-1:0] w_btn_val_nxt;
    logic             r_win;
    logic             w_win_nxt;
    logic             r_lose;
    logic             w_lose_nxt;

    logic             w_last;
    logic             w_match;

    // idx is the last step of the sequence when it equals len-1
    assign w_last  = ({1'b0, r_idx} == (r_len - c_ONE_LEN));
    assign w_match = (mem.mem_data_out == r_btn_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_show_val <= '0;
            r_btn_val  <= '0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_show_val <= w_show_val_nxt;
            r_btn_val  <= w_btn_val_nxt;
            r_win      <= w_win_nxt;
            r_lose     <= w_lose_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_idx_nxt       = r_idx;
        w_show_val_nxt  = r_show_val;
        w_btn_val_nxt   = r_btn_val;
        w_win_nxt       = 1'b0;
        w_lose_nxt      = 1'b0;
        mem.mem_w_en    = 1'b0;
        mem.mem_w_ptr   = '0;
        mem.mem_data_in = '0;
        mem.mem_r_en    = 1'b0;
        mem.mem_r_ptr   = '0;
        show_valid      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_len_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_APPEND;
                end
            end
            S_APPEND: begin
                mem.mem_w_en    = 1'b1;
                mem.mem_w_ptr   = r_len[PTR_W-1:0];
                mem.mem_data_in = rand_val;
                w_len_nxt       = r_len + c_ONE_LEN;
                w_idx_nxt       = '0;
                w_state_nxt     = S_PLAY_REQ;
            end
            S_PLAY_REQ: begin
                mem.mem_r_en  = 1'b1;
                mem.mem_r_ptr = r_idx;
                w_state_nxt   = S_PLAY_CAP;
            end
            S_PLAY_CAP: begin
                w_show_val_nxt = mem.mem_data_out;
                w_state_nxt    = S_PLAY_SHOW;
            end
            S_PLAY_SHOW: begin
                show_valid = 1'b1;
                if (tick) begin
                    if (w_last) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_IN_WAIT;
                    end else begin
                        w_idx_nxt   = r_idx + c_ONE_IDX;
                        w_state_nxt = S_PLAY_REQ;
                    end
                end
            end
            S_IN_WAIT: begin
                if (btn_valid) begin
                    w_btn_val_nxt = btn_val;
                    w_state_nxt   = S_IN_REQ;
                end
            end
            S_IN_REQ: begin
                mem.mem_r_en  = 1'b1;
                mem.mem_r_ptr = r_idx;
                w_state_nxt   = S_IN_CMP;
            end
            S_IN_CMP: begin
                // Result pulses are registered so they land in the cycle the FSM is back in IDLE
                if (!w_match) begin
                    w_lose_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (!w_last) begin
                    w_idx_nxt   = r_idx + c_ONE_IDX;
                    w_state_nxt = S_IN_WAIT;
                end else if (r_len < c_DEPTH) begin
                    w_state_nxt = S_APPEND;
                end else begin
                    w_win_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign show_val = r_show_val;
    assign level    = r_len;
    assign busy     = (r_state != S_IDLE);
    assign win      = r_win;
    assign lose     = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_simon_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_seq_ctrl
// Purpose  : Self-checking bench for simon_seq_ctrl against a game-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_seq_ctrl;

    localparam int DEPTH = 32;
    localparam int WIDTH = 6;
    localparam int PTR_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] rand_val;
    logic             tick;
    logic             btn_valid;
    logic [WIDTH-1:0] btn_val;
    logic             show_valid;
    logic [WIDTH-1:0] show_val;
    logic [PTR_W:0]   level;
    logic             busy;
    logic             win;
    logic             lose;

    simon_seq_ctrl_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) mif ();

    simon_seq_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rand_val   (rand_val),
        .tick       (tick),
        .btn_valid  (btn_valid),
        .btn_val    (btn_val),
        .mem        (mif),
        .show_valid (show_valid),
        .show_val   (show_val),
        .level      (level),
        .busy       (busy),
        .win        (win),
        .lose       (lose)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data appears the cycle after the read enable is sampled
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mif.mem_w_en) ram[mif.mem_w_ptr] <= mif.mem_data_in;
        if (mif.mem_r_en) mif.mem_data_out <= ram[mif.mem_r_ptr];
    end

    int checks   = 0;
    int failures = 0;
    int n_wr     = 0;
    int n_rd     = 0;
    int exp_wr   = 0;
    int exp_rd   = 0;

    logic [WIDTH-1:0] seq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Port-level rules that hold every cycle
    always @(negedge clk) begin
        if (mif.mem_w_en) n_wr++;
        if (mif.mem_r_en) n_rd++;
        chk("rw_exclusive", {31'd0, mif.mem_w_en & mif.mem_r_en}, 0);
        if (!mif.mem_w_en) chk("wr_idle_zero", {20'd0, mif.mem_w_ptr, mif.mem_data_in}, 0);
        if (!mif.mem_r_en) chk("rd_idle_zero", {27'd0, mif.mem_r_ptr}, 0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_w_en"}, mif.mem_w_en, 0);
        chk({tag, "_w_ptr"}, mif.mem_w_ptr, 0);
        chk({tag, "_din"}, mif.mem_data_in, 0);
        chk({tag, "_r_en"}, mif.mem_r_en, 0);
        chk({tag, "_r_ptr"}, mif.mem_r_ptr, 0);
        chk({tag, "_show_valid"}, show_valid, 0);
        chk({tag, "_show_val"}, show_val, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_win"}, win, 0);
        chk({tag, "_lose"}, lose, 0);
    endtask

    // Precondition: FSM idle. Leaves the bench sampling the first APPEND cycle.
    task automatic start_game(input logic [WIDTH-1:0] v);
        start    = 1'b1;
        rand_val = v;
        cyc();
        start = 1'b0;
        chk("start_w_en", mif.mem_w_en, 1);
        chk("start_w_ptr", mif.mem_w_ptr, 0);
        chk("start_din", mif.mem_data_in, v);
        chk("start_busy", busy, 1);
        chk("start_level", level, 0);
        seq.delete();
        seq.push_back(v);
        exp_wr++;
    endtask

    // Entry: sampling an APPEND cycle. Exit: sampling the first IN_WAIT cycle.
    task automatic playback();
        int n;
        n = seq.size();
        for (int i = 0; i < n; i++) begin
            cyc();
            tick = 1'b0;
            exp_rd++;
            chk("pb_r_en", mif.mem_r_en, 1);
            chk("pb_r_ptr", mif.mem_r_ptr, i);
            chk("pb_req_show_valid", show_valid, 0);
            cyc();
            chk("pb_cap_show_valid", show_valid, 0);
            cyc();
            chk("pb_show_valid", show_valid, 1);
            chk("pb_show_val", show_val, seq[i]);
            chk("pb_level", level, n);
            repeat ($urandom_range(0, 2)) begin
                btn_valid = 1'($urandom_range(0, 1));
                start     = 1'($urandom_range(0, 1));
                btn_val   = WIDTH'($urandom);
                cyc();
                btn_valid = 1'b0;
                start     = 1'b0;
                chk("pb_hold_valid", show_valid, 1);
                chk("pb_hold_val", show_val, seq[i]);
            end
            tick = 1'b1;
        end
        cyc();
        tick = 1'b0;
        chk("wait_show_valid", show_valid, 0);
        chk("wait_busy", busy, 1);
    endtask

    // Entry: sampling IN_WAIT at step 0. Drives one reply per step (err_pos gets err_val).
    task automatic input_round(input int err_pos, input logic [WIDTH-1:0] err_val,
                               input logic [WIDTH-1:0] next_v,
                               output bit lost, output bit won, output logic obs_lose);
        int n;
        logic [WIDTH-1:0] v;
        n        = seq.size();
        lost     = 1'b0;
        won      = 1'b0;
        obs_lose = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                tick  = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
                cyc();
                tick  = 1'b0;
                start = 1'b0;
                chk("in_wait_busy", busy, 1);
                chk("in_wait_mem", {30'd0, mif.mem_w_en, mif.mem_r_en}, 0);
                chk("in_wait_show", show_valid, 0);
            end
            v         = (i == err_pos) ? err_val : seq[i];
            btn_valid = 1'b1;
            btn_val   = v;
            rand_val  = next_v;
            cyc();
            btn_valid = 1'b0;
            btn_val   = WIDTH'($urandom);
            exp_rd++;
            chk("in_r_en", mif.mem_r_en, 1);
            chk("in_r_ptr", mif.mem_r_ptr, i);
            cyc();
            chk("in_cmp_result", {30'd0, win, lose}, 0);
            cyc();
            if (v != seq[i]) begin
                obs_lose = lose;
                chk("lose_pulse", lose, 1);
                chk("lose_win", win, 0);
                chk("lose_busy", busy, 0);
                chk("lose_level", level, n);
                lost = 1'b1;
                cyc();
                chk("lose_single", lose, 0);
                chk("lose_level_hold", level, n);
                return;
            end else if (i < n - 1) begin
                chk("match_result", {30'd0, win, lose}, 0);
                chk("match_busy", busy, 1);
            end else if (n < DEPTH) begin
                chk("grow_w_en", mif.mem_w_en, 1);
                chk("grow_w_ptr", mif.mem_w_ptr, n);
                chk("grow_din", mif.mem_data_in, next_v);
                chk("grow_result", {30'd0, win, lose}, 0);
                seq.push_back(next_v);
                exp_wr++;
                return;
            end else begin
                chk("win_pulse", win, 1);
                chk("win_no_write", mif.mem_w_en, 0);
                chk("win_busy", busy, 0);
                chk("win_level", level, DEPTH);
                won = 1'b1;
                cyc();
                chk("win_single", win, 0);
                return;
            end
        end
    endtask

    typedef struct {
        bit               new_game;
        logic [WIDTH-1:0] val;
        int               err_pos;
        logic [WIDTH-1:0] err_val;
        int               exp_level;
        logic             exp_lose;
    } vec_t;

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        bit   lost, won;
        logic obs;
        logic [WIDTH-1:0] nv;
        int   guard;

        tbl[0] = '{1'b1, 6'd5,  -1, 6'd0,  1, 1'b0};
        tbl[1] = '{1'b0, 6'd9,   1, 6'd3,  2, 1'b1};
        tbl[2] = '{1'b1, 6'd7,   0, 6'd2,  1, 1'b1};
        tbl[3] = '{1'b1, 6'd63, -1, 6'd0,  1, 1'b0};
        tbl[4] = '{1'b0, 6'd0,  -1, 6'd0,  2, 1'b0};
        tbl[5] = '{1'b0, 6'd42,  2, 6'd41, 3, 1'b1};

        rst_n     = 1'b0;
        start     = 1'b0;
        rand_val  = '0;
        tick      = 1'b0;
        btn_valid = 1'b0;
        btn_val   = '0;
        repeat (3) cyc();
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Strobes in IDLE must not wake the controller
        repeat (4) begin
            btn_valid = 1'b1;
            tick      = 1'b1;
            btn_val   = WIDTH'($urandom);
            cyc();
            chk("idle_busy", busy, 0);
            chk("idle_mem", {30'd0, mif.mem_w_en, mif.mem_r_en}, 0);
        end
        btn_valid = 1'b0;
        tick      = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].new_game) start_game(tbl[i].val);
            playback();
            chk($sformatf("tbl%0d_level", i), level, tbl[i].exp_level);
            nv = (i < 5) ? tbl[i + 1].val : 6'd0;
            input_round(tbl[i].err_pos, tbl[i].err_val, nv, lost, won, obs);
            chk($sformatf("tbl%0d_lose", i), obs, tbl[i].exp_lose);
        end

        // Randomised games with an occasional wrong reply
        for (int g = 0; g < 8; g++) begin
            int ep;
            logic [WIDTH-1:0] ev;
            start_game(WIDTH'($urandom));
            guard = 0;
            do begin
                playback();
                if (seq.size() >= 5 || $urandom_range(0, 3) == 0) begin
                    ep = int'($urandom_range(0, seq.size() - 1));
                    ev = seq[ep] ^ WIDTH'($urandom_range(1, 63));
                end else begin
                    ep = -1;
                    ev = '0;
                end
                input_round(ep, ev, WIDTH'($urandom), lost, won, obs);
                guard++;
            end while (!lost && !won && guard < 40);
            chk("rand_game_lost", {31'd0, lose | lost}, 1);
        end

        // Full-depth game: step k holds value k, every reply correct
        start_game(6'd0);
        guard = 0;
        do begin
            playback();
            input_round(-1, 6'd0, WIDTH'(seq.size()), lost, won, obs);
            guard++;
        end while (!lost && !won && guard < 40);
        chk("full_won", {31'd0, won}, 1);
        chk("full_level", level, DEPTH);
        chk("full_len", seq.size(), DEPTH);

        // Asynchronous reset while showing a step at level 3
        start_game(6'd1);
        playback();
        input_round(-1, 6'd0, 6'd2, lost, won, obs);
        playback();
        input_round(-1, 6'd0, 6'd3, lost, won, obs);
        cyc();
        exp_rd++;
        chk("rst_pre_level", level, 3);
        cyc();
        cyc();
        chk("rst_pre_show", show_valid, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_busy", busy, 0);
        start_game(6'd11);
        playback();
        input_round(0, 6'd12, 6'd0, lost, won, obs);
        chk("post_rst_lose", obs, 1);

        cyc();
        chk("total_writes", n_wr, exp_wr);
        chk("total_reads", n_rd, exp_rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simon_seq_ctrl.md
SIMON_SEQ_CTRL -- requirements
Module: simon_seq_ctrl

Interface
REQ-001 Parameter DEPTH, 32, maximum sequence length and memory entry count.
REQ-002 Parameter WIDTH, 6, bits per sequence step (memory data width).
REQ-003 Parameter PTR_W, 5, memory pointer width (log2 DEPTH).
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a new game.
REQ-007 rand_val  input  WIDTH  next random step value, sampled in APPEND.
REQ-008 tick  input  1  single-cycle playback pacing strobe.
REQ-009 btn_valid  input  1  single-cycle player-input strobe.
REQ-010 btn_val  input  WIDTH  player step value, qualified by btn_valid.
REQ-011 mem_w_ptr / mem_w_en / mem_data_in  output  PTR_W / 1 / WIDTH  memory write port.
REQ-012 mem_r_ptr / mem_r_en  output  PTR_W / 1  memory read port.
REQ-013 mem_data_out  input  WIDTH  memory read data; valid in the cycle after mem_r_en is sampled high.
REQ-014 show_valid / show_val  output  1 / WIDTH  playback step presented to the display.
REQ-015 level  output  PTR_W+1  current sequence length, 0..DEPTH.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 win / lose  output  1 / 1  single-cycle game-result pulses.

Function
REQ-018 States: IDLE, APPEND, PLAY_REQ, PLAY_CAP, PLAY_SHOW, IN_WAIT, IN_REQ, IN_CMP; registered one-hot or binary, implementer's choice.
REQ-019 IDLE: start=1 -> len<=0 -> APPEND; all other inputs ignored.
REQ-020 APPEND: mem_w_en=1, mem_w_ptr=len, mem_data_in=rand_val for exactly one cycle; len<=len+1, idx<=0 -> PLAY_REQ.
REQ-021 PLAY_REQ: mem_r_en=1, mem_r_ptr=idx for one cycle -> PLAY_CAP.
REQ-022 PLAY_CAP: show_val<=mem_data_out -> PLAY_SHOW.
REQ-023 PLAY_SHOW: show_valid=1; on tick: if idx==len-1 then idx<=0 -> IN_WAIT, else idx<=idx+1 -> PLAY_REQ; tick outside PLAY_SHOW ignored.
REQ-024 show_valid low in every state other than PLAY_SHOW; show_val holds last captured value.
REQ-025 IN_WAIT: on btn_valid capture btn_val -> IN_REQ; btn_valid in any other state ignored (not queued).
REQ-026 IN_REQ: mem_r_en=1, mem_r_ptr=idx for one cycle -> IN_CMP.
REQ-027 IN_CMP: mismatch -> lose=1 one cycle -> IDLE; match and idx<len-1 -> idx<=idx+1 -> IN_WAIT; match and idx==len-1 and len<DEPTH -> APPEND; match and idx==len-1 and len==DEPTH -> win=1 one cycle -> IDLE.
REQ-028 level=len at all times; len and idx never exceed DEPTH and DEPTH-1; no pointer wrap-around occurs.
REQ-029 mem_w_en and mem_r_en never high in the same cycle; pointers/data outputs are 0 when corresponding enable is low.
REQ-030 start outside IDLE is ignored (no restart mid-game); level retains final value in IDLE until the next start.
REQ-031 Latency: start to first mem_w_en = 1 cycle; PLAY_REQ to show_valid = 2 cycles; btn_valid to win/lose = 3 cycles.

Reset
REQ-032 rst_n=0 forces IDLE immediately, asynchronously, including mid-game.
REQ-033 Reset values: len=0, idx=0, show_val=0, all outputs 0 (mem enables, pointers, data, show_valid, level, busy, win, lose).
REQ-034 Memory contents are not cleared; reset-then-start overwrites from address 0.

Verification
REQ-035 Reset, start, rand_val=6'd5 -> one write ptr 0 data 5, level=1, show_valid with show_val=5 two cycles after PLAY_REQ.
REQ-036 Level 1 then btn_val=5 -> APPEND at ptr 1 with rand_val=6'd9; playback shows 5 then 9, each held until tick.
REQ-037 Level 2 sequence {5,9}, inputs 5 then 3 -> lose pulse exactly 3 cycles after second btn_valid, busy=0, level=2.
REQ-038 Fill 32 steps with rand_val=idx and correct inputs -> win pulse after 32nd match, no write at 32, level=32.
REQ-039 btn_valid and tick during playback/IDLE, start mid-game -> no state change, no extra memory access.
REQ-040 rst_n low in PLAY_SHOW at level 3 -> all outputs 0 asynchronously; subsequent start writes ptr 0.
